// File: rtl/nmcu_pkg.sv
// Shared types for the NMCU scheduler: FSM state encoding and default bus/dimension widths.
package nmcu_pkg;

   localparam int ADDR_W_DEF  = 16;
   localparam int MAX_DIM_DEF = 15;
   localparam int DIM_W       = $clog2(MAX_DIM_DEF) + 1;

   typedef logic [ADDR_W_DEF-1:0] addr_t;
   typedef logic [DIM_W-1:0]      dim_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_RD,
      GAP,
      WAIT_DONE,
      FINISH,
      ERROR
   } state_e;

endpackage

// File: rtl/nmcu_addr_gen.sv
// Tile address walker: column counter plus running row/input/output accumulators.
// The accumulators always hold the addresses of the tile currently being issued.
module nmcu_addr_gen #(
   parameter int AW = 16,
   parameter int DW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic          adv_i,
   input  logic [AW-1:0] in_base_i,
   input  logic [AW-1:0] out_base_i,
   input  logic [DW-1:0] in_pitch_i,
   input  logic [DW-1:0] out_cols_i,
   output logic [AW-1:0] in_addr_o,
   output logic [AW-1:0] out_addr_o
);

   logic [DW-1:0] col_q, col_d;
   logic [AW-1:0] row_q, row_d, in_q, in_d, out_q, out_d;
   logic [AW-1:0] pitch;

   assign pitch = AW'(in_pitch_i);

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      in_d  = in_q;
      out_d = out_q;
      if (load_i) begin
         col_d = '0;
         row_d = in_base_i;
         in_d  = in_base_i;
         out_d = out_base_i;
      end else if (adv_i) begin
         out_d = out_q + AW'(1);
         // End of an output row: jump the input pointer to the next input row.
         if (col_q == out_cols_i - DW'(1)) begin
            col_d = '0;
            row_d = row_q + pitch;
            in_d  = row_q + pitch;
         end else begin
            col_d = col_q + DW'(1);
            in_d  = in_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q <= '0;
         row_q <= '0;
         in_q  <= '0;
         out_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         in_q  <= in_d;
         out_q <= out_d;
      end
   end

   assign in_addr_o  = in_q;
   assign out_addr_o = out_q;

endmodule

// File: rtl/nmcu_scheduler.sv
// Serialises NMCU tile launches for one convolution layer and merges their completion.
// Define NMCU_TIMEOUT_EN to add a read-phase watchdog that aborts to ERROR.
module nmcu_scheduler
   import nmcu_pkg::*;
#(
   parameter int ADDR_WIDTH     = 16,
   parameter int NUM_NMCUS      = 9,
   parameter int MAX_INPUT_DIM  = 15,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            launch,
   input  logic [ADDR_WIDTH-1:0]           input_base,
   input  logic [ADDR_WIDTH-1:0]           output_base,
   input  logic [$clog2(MAX_INPUT_DIM):0]  full_input_width,
   input  logic [$clog2(MAX_INPUT_DIM):0]  full_output_width,
   input  logic [$clog2(MAX_INPUT_DIM):0]  full_output_height,
   output logic [NUM_NMCUS-1:0]            nmcu_start,
   output logic [NUM_NMCUS*ADDR_WIDTH-1:0] nmcu_input_addr,
   output logic [NUM_NMCUS*ADDR_WIDTH-1:0] nmcu_output_addr,
   input  logic [NUM_NMCUS-1:0]            nmcu_read_complete,
   input  logic [NUM_NMCUS-1:0]            nmcu_done,
   input  logic [NUM_NMCUS-1:0]            nmcu_mem_w,
   input  logic [NUM_NMCUS-1:0]            nmcu_mem_sel,
   output logic                            mem_w,
   output logic                            mem_sel,
   output logic                            busy,
   output logic                            all_done,
   output logic                            error
);

   localparam int DW = $clog2(MAX_INPUT_DIM) + 1;
   localparam int NW = 2 * DW;
   localparam int KW = (NUM_NMCUS > 1) ? $clog2(NUM_NMCUS) : 1;

   state_e                               state_q, state_d;
   logic [KW-1:0]                        k_q, k_d;
   logic [NW-1:0]                        n_q, n_launch;
   logic [DW-1:0]                        fiw_q, fow_q;
   logic [NUM_NMCUS-1:0]                 active_q, mask_q, start_q, act_launch;
   logic [NUM_NMCUS-1:0][ADDR_WIDTH-1:0] in_addr_q, out_addr_q;
   logic                                 busy_q, all_done_q, error_q;
   logic                                 accept, last, rc_k, tmo;
   logic [ADDR_WIDTH-1:0]                gen_in, gen_out;

   assign n_launch = NW'(full_output_width) * NW'(full_output_height);
   assign accept   = launch && (state_q == IDLE || state_q == ERROR);
   assign last     = (NW'(k_q) == n_q - NW'(1));
   assign rc_k     = nmcu_read_complete[k_q];

   for (genvar g = 0; g < NUM_NMCUS; g++) begin : g_act
      assign act_launch[g] = (NW'(g) < n_launch);
   end

`ifdef NMCU_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  tmo_q <= '0;
      else if (state_q != WAIT_RD) tmo_q <= '0;
      else                       tmo_q <= tmo_q + TW'(1);
   end

   assign tmo = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_tmo;
   assign tmo        = 1'b0;
   assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

   nmcu_addr_gen #(.AW(ADDR_WIDTH), .DW(DW)) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .load_i    (accept),
      .adv_i     (state_q == GAP && !last),
      .in_base_i (input_base),
      .out_base_i(output_base),
      .in_pitch_i(fiw_q),
      .out_cols_i(fow_q),
      .in_addr_o (gen_in),
      .out_addr_o(gen_out)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      case (state_q)
         IDLE, ERROR: begin
            if (launch) begin
               state_d = ISSUE;
               k_d     = '0;
            end
         end
         ISSUE: begin
            if (n_q == '0)                    state_d = WAIT_DONE;
            else if (n_q > NW'(NUM_NMCUS))    state_d = ERROR;
            else                              state_d = WAIT_RD;
         end
         WAIT_RD: begin
            if (rc_k)     state_d = GAP;
            else if (tmo) state_d = ERROR;
         end
         GAP: begin
            if (last) state_d = WAIT_DONE;
            else begin
               state_d = ISSUE;
               k_d     = k_q + KW'(1);
            end
         end
         WAIT_DONE: begin
            if ((mask_q | (nmcu_done & active_q)) == active_q) state_d = FINISH;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         k_q        <= '0;
         n_q        <= '0;
         fiw_q      <= '0;
         fow_q      <= '0;
         active_q   <= '0;
         mask_q     <= '0;
         start_q    <= '0;
         in_addr_q  <= '0;
         out_addr_q <= '0;
         busy_q     <= 1'b0;
         all_done_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         start_q    <= '0;
         busy_q     <= state_d inside {ISSUE, WAIT_RD, GAP, WAIT_DONE};
         all_done_q <= (state_d == FINISH);
         error_q    <= (state_d == ERROR);
         if (accept) begin
            n_q        <= n_launch;
            fiw_q      <= full_input_width;
            fow_q      <= full_output_width;
            active_q   <= act_launch;
            mask_q     <= '0;
            in_addr_q  <= '0;
            out_addr_q <= '0;
         end else begin
            // Done bits may pulse early; keep them until the layer finishes.
            mask_q <= mask_q | (nmcu_done & active_q);
         end
         if (state_q == ISSUE && state_d == WAIT_RD) begin
            start_q[k_q]    <= 1'b1;
            in_addr_q[k_q]  <= gen_in;
            out_addr_q[k_q] <= gen_out;
         end
      end
   end

   assign nmcu_start       = start_q;
   assign nmcu_input_addr  = in_addr_q;
   assign nmcu_output_addr = out_addr_q;
   assign mem_w            = |nmcu_mem_w;
   assign mem_sel          = |nmcu_mem_sel;
   assign busy             = busy_q;
   assign all_done         = all_done_q;
   assign error            = error_q;

endmodule
